dma_pingpong_ctrl: RTL
======================

# dma_pingpong_ctrl

Ping-pong sequencer for one DMA port pair in the DMA engine: owns the two 512x32 single-port SRAM banks behind one PE-array port. It writes an incoming stream into one bank while draining the previously filled bank to the output, and swaps banks on frame boundaries. The DMA top instantiates one per port (DMA_PORTS instances), replacing the free-running bank addressing.

## Interface
- DATA_WIDTH, 32, stream and SRAM word width
- ADDR_WIDTH, 9, bank address width; bank depth = 2**ADDR_WIDTH
- FRAME_CNT_W, 16, width of frame counter
- clk  in  1  clock; one clock domain
- rst  in  1  reset, synchronous, active-high
- start  in  1  pulse; accepted only in IDLE
- cfg_len  in  ADDR_WIDTH+1  words per frame, latched on start
- cfg_frames  in  FRAME_CNT_W  frames per job, latched on start
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse when last word of job leaves out port
- in_valid / in_ready  in / out  1 / 1  input handshake
- in_data  in  DATA_WIDTH  input word
- out_valid / out_ready  out / in  1 / 1  output handshake
- out_data  out  DATA_WIDTH  output word
- bank_ceb  out  2  per-bank chip enable, active-low
- bank_web  out  2  per-bank write enable, active-low
- bank_a  out  2 x ADDR_WIDTH  per-bank address
- bank_d  out  DATA_WIDTH  write data, shared by both banks
- bank_q  in  2 x DATA_WIDTH  per-bank read data, valid 1 cycle after read
- stat_fill_wait, stat_drain_wait  out  32 each  stall counters (see Configuration)

## Operation
- States: IDLE, PRIME, STREAM, DRAIN.
- IDLE:
  - start with cfg_len != 0 and cfg_frames != 0 latches config, sets wsel=0, clears counters, goes to PRIME.
  - start with a zero field is ignored.
  - cfg_len > 2**ADDR_WIDTH is clamped to 2**ADDR_WIDTH.
- PRIME:
  - in_ready=1 while wcnt < len.
  - Each in_valid&in_ready writes in_data to bank wsel at address wcnt, then wcnt++.
  - When wcnt reaches len: frames_filled=1. If frames_filled == cfg_frames, go to DRAIN with rsel=wsel. Otherwise go to STREAM with rsel=wsel, wsel=~wsel, wcnt=0, rcnt=0.
- STREAM:
  - Concurrent fill of bank wsel and drain of bank rsel; wsel != rsel always.
  - Fill rule is as in PRIME.
  - Drain issues a read (ceb=0, web=1, a=rcnt) and increments rcnt when rcnt < len and skid occupancy + reads in flight < 2.
  - Swap happens when wcnt==len and all len words of the drain have been accepted at the out port. On swap: frames_filled++, rsel=wsel, wsel=~wsel, wcnt=rcnt=0.
  - If the completed fill was the last frame, go to DRAIN instead of swapping the fill side.
- DRAIN: drain bank rsel only; in_ready=0. When the last word is accepted at the out port, pulse done and go to IDLE.
- Idle banks have bank_ceb=1 and bank_web=1. bank_a holds its last value.
- Output path is a 2-entry skid buffer fed by bank_q[rsel_d1]. out_valid = buffer not empty.
- in_valid outside an in_ready window is not consumed; there is no error flag.
- start while busy is ignored.
- rst mid-job: abort immediately, return to IDLE, flush the skid buffer. No done pulse.

## Timing
- Reset values: busy=0, done=0, in_ready=0, out_valid=0, out_data=0, bank_ceb=2'b11, bank_web=2'b11, bank_a=0, bank_d=0, stats=0.
- start to first in_ready: 1 cycle (in_ready high in the cycle after start is sampled).
- Input handshake to SRAM write: same cycle. bank_d=in_data and bank_web[wsel]=0 combinationally from the handshake.
- SRAM read to out_valid: 2 cycles (1 SRAM latency + 1 skid register). With out_ready held high, the drain sustains 1 word/cycle.
- Swap decision: registered. The first fill write and first drain read of the new frame occur in the cycle after the swap condition.
- done pulse: the cycle after the last out handshake.

## Configuration
- DMA_PP_STATS_EN defined:
  - stat_fill_wait increments each STREAM cycle with wcnt==len and the drain incomplete.
  - stat_drain_wait increments each STREAM cycle with the drain complete and wcnt<len.
  - Both saturate at 2**32-1 and clear on start and on rst.
- DMA_PP_STATS_EN undefined: both ports tied to 0 and no counter flops are built.

## Structure
- Package dma_pp_pkg holds:
  - state enum dma_pp_state_e (IDLE, PRIME, STREAM, DRAIN)
  - localparam SRAM_RD_LAT = 1
  - SKID_DEPTH = 2
- Sub-module dma_pp_skid: 2-entry valid/ready output buffer with occupancy output, used for read-credit accounting.

## Test plan
- len=4, frames=1, out_ready=1: in_data 1..4 -> bank0 written at addr 0..3, out emits 1,2,3,4, done pulse, busy=0; bank1 CEB stays 1.
- len=3, frames=3, full rate both sides: in 1..9 -> out 1..9 in order; bank use alternates 0,1,0; stat counters 0.
- len=512, frames=2, out_ready low for 600 cycles: fill of frame 2 completes and stalls. stat_fill_wait > 0, in_ready=0 after 512 words; data intact after release.
- out_ready toggling 1010 during drain: no word dropped or duplicated; skid never exceeds 2 entries.
- rst asserted mid-STREAM: next cycle busy=0, out_valid=0, bank_ceb=2'b11. A new start with len=2 works normally.
- start with cfg_len=0 or start while busy -> ignored; state and counters unchanged.

Source files
------------

// File: rtl/dma_pp_pkg.sv
// dma_pp_pkg: shared state encoding and pipeline constants for the ping-pong DMA sequencer
package dma_pp_pkg;
  typedef enum logic [1:0] {IDLE, PRIME, STREAM, DRAIN} dma_pp_state_e;
  localparam int SRAM_RD_LAT = 1;
  localparam int SKID_DEPTH = 2;
endpackage

// File: rtl/dma_pp_skid.sv
// dma_pp_skid: 2-entry valid/ready output buffer; occupancy feeds the read-credit check
module dma_pp_skid #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_valid,
  input  logic [DW-1:0] i_data,
  input  logic          i_ready,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  output logic [1:0]    o_occ
);
  logic [DW-1:0] r_q0, r_q1;
  logic [1:0] r_cnt;
  logic w_pop;
  assign w_pop = o_valid && i_ready;
  assign o_valid = r_cnt != 2'd0;
  assign o_data = r_q0;
  assign o_occ = r_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_q0 <= '0;
      r_q1 <= '0;
    end else begin
      r_cnt <= r_cnt + {1'b0, i_valid} - {1'b0, w_pop};
      if (w_pop) r_q0 <= (r_cnt == 2'd2) ? r_q1 : i_data;
      else if (i_valid && r_cnt == 2'd0) r_q0 <= i_data;
      // q1 is only observed once it holds the second-oldest word
      if (i_valid) r_q1 <= i_data;
    end
  end
endmodule

// File: rtl/dma_pingpong_ctrl.sv
// dma_pingpong_ctrl: fills one SRAM bank while draining the other, swapping on frame boundaries
// Optional stall counters built only with DMA_PP_STATS_EN defined.
module dma_pingpong_ctrl
  import dma_pp_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 9,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [ADDR_WIDTH:0]        cfg_len,
  input  logic [FRAME_CNT_W-1:0]     cfg_frames,
  output logic                       busy,
  output logic                       done,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_WIDTH-1:0]      in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic [1:0]                 bank_ceb,
  output logic [1:0]                 bank_web,
  output logic [1:0][ADDR_WIDTH-1:0] bank_a,
  output logic [DATA_WIDTH-1:0]      bank_d,
  input  logic [1:0][DATA_WIDTH-1:0] bank_q,
  output logic [31:0]                stat_fill_wait,
  output logic [31:0]                stat_drain_wait
);
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  dma_pp_state_e r_state, w_nxt;
  logic [ADDR_WIDTH:0] r_len, r_wcnt, r_rcnt, r_ocnt;
  logic [FRAME_CNT_W-1:0] r_frames, r_filled, w_filled_inc;
  logic r_wsel, r_rsel, r_done;
  logic [SRAM_RD_LAT-1:0] r_rd_p, r_rs_p;
  logic [1:0][ADDR_WIDTH-1:0] r_a;
  logic [1:0] w_occ, w_wen, w_ren;
  logic w_go, w_wr, w_rd, w_pop, w_fdone, w_ddone, w_swap, w_last, w_cred;
  assign w_go = r_state == IDLE && start && cfg_len != '0 && cfg_frames != '0;
  assign w_fdone = r_wcnt == r_len;
  assign w_ddone = r_ocnt == r_len;
  assign busy = r_state != IDLE;
  assign done = r_done;
  assign in_ready = (r_state == PRIME || r_state == STREAM) && !w_fdone;
  assign w_wr = in_valid && in_ready;
  assign w_pop = out_valid && out_ready;
  // a word leaving this cycle frees its slot, so the drain can sustain one word per cycle
  assign w_cred = int'(w_occ) + $countones(r_rd_p) - int'(w_pop) < SKID_DEPTH;
  assign w_rd = (r_state == STREAM || r_state == DRAIN) && r_rcnt != r_len && w_cred;
  assign w_swap = w_fdone && (r_state == PRIME || (r_state == STREAM && w_ddone));
  assign w_filled_inc = r_filled + 1'b1;
  assign w_last = r_state == DRAIN && w_pop && r_ocnt == r_len - 1'b1;
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:          w_nxt = w_go ? PRIME : IDLE;
      PRIME, STREAM: w_nxt = w_swap ? (w_filled_inc == r_frames ? DRAIN : STREAM) : r_state;
      default:       w_nxt = w_last ? IDLE : DRAIN;
    endcase
  end
  assign w_wen = w_wr ? (r_wsel ? 2'b10 : 2'b01) : 2'b00;
  assign w_ren = w_rd ? (r_rsel ? 2'b10 : 2'b01) : 2'b00;
  assign bank_web = ~w_wen;
  assign bank_ceb = ~(w_wen | w_ren);
  assign bank_d = w_wr ? in_data : '0;
  for (genvar b = 0; b < 2; b++) begin : g_a
    assign bank_a[b] = w_wen[b] ? r_wcnt[ADDR_WIDTH-1:0] : w_ren[b] ? r_rcnt[ADDR_WIDTH-1:0] : r_a[b];
  end
  dma_pp_skid #(.DW(DATA_WIDTH)) u_skid (
    .clk(clk), .rst(rst), .i_valid(r_rd_p[SRAM_RD_LAT-1]), .i_data(bank_q[r_rs_p[SRAM_RD_LAT-1]]),
    .i_ready(out_ready), .o_valid(out_valid), .o_data(out_data), .o_occ(w_occ)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_done <= 1'b0;
      r_rd_p <= '0;
      r_rs_p <= '0;
      r_a <= '0;
      r_len <= '0;
      r_frames <= '0;
      r_filled <= '0;
      r_wsel <= 1'b0;
      r_rsel <= 1'b0;
      r_wcnt <= '0;
      r_rcnt <= '0;
      r_ocnt <= '0;
    end else begin
      r_state <= w_nxt;
      r_done <= w_last;
      r_rd_p <= SRAM_RD_LAT'({r_rd_p, w_rd});
      r_rs_p <= SRAM_RD_LAT'({r_rs_p, r_rsel});
      r_a <= bank_a;
      if (w_wr) r_wcnt <= r_wcnt + 1'b1;
      if (w_rd) r_rcnt <= r_rcnt + 1'b1;
      if (w_pop) r_ocnt <= r_ocnt + 1'b1;
      if (w_go) begin
        r_len <= cfg_len > DEPTH ? DEPTH : cfg_len;
        r_frames <= cfg_frames;
        r_filled <= '0;
        r_wsel <= 1'b0;
        r_rsel <= 1'b0;
        r_wcnt <= '0;
        r_rcnt <= '0;
        r_ocnt <= '0;
      end
      if (w_swap) begin
        r_filled <= w_filled_inc;
        r_rsel <= r_wsel;
        r_wsel <= ~r_wsel;
        r_wcnt <= '0;
        r_rcnt <= '0;
        r_ocnt <= '0;
      end
    end
  end
`ifdef DMA_PP_STATS_EN
  logic [31:0] r_fw, r_dw;
  always_ff @(posedge clk) begin
    if (rst || w_go) begin
      r_fw <= '0;
      r_dw <= '0;
    end else begin
      if (r_state == STREAM && w_fdone && !w_ddone && r_fw != '1) r_fw <= r_fw + 1'b1;
      if (r_state == STREAM && w_ddone && !w_fdone && r_dw != '1) r_dw <= r_dw + 1'b1;
    end
  end
  assign stat_fill_wait = r_fw;
  assign stat_drain_wait = r_dw;
`else
  assign stat_fill_wait = '0;
  assign stat_drain_wait = '0;
`endif
endmodule
